// File: rtl/sher_vi_pkg.sv
// Shared SHER-VI definitions: opcodes, fetch FSM encodings and instruction field boundaries.
// Used by both the fetch unit and the control unit.
package sher_vi_pkg;

  localparam int CODE_W   = 5;
  localparam int OPND_W   = 27;
  localparam int CODE_MSB = 31;
  localparam int CODE_LSB = 27;
  localparam int OPND_MSB = 26;
  localparam int OPND_LSB = 0;

  localparam logic [CODE_W-1:0] OP_MAKE   = 5'd0;
  localparam logic [CODE_W-1:0] OP_ADDSP  = 5'd1;
  localparam logic [CODE_W-1:0] OP_ARITH  = 5'd2;
  localparam logic [CODE_W-1:0] OP_BRANCH = 5'd3;
  localparam logic [CODE_W-1:0] OP_SUBSP  = 5'd5;
  localparam logic [CODE_W-1:0] OP_JUMP   = 5'd19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/sher_vi_opcode_check.sv
// Combinational opcode legality check, shared by fetch and control.
module sher_vi_opcode_check
  import sher_vi_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic              legal
);

  always_comb begin
    legal = 1'b0;
    case (code)
      OP_MAKE, OP_ADDSP, OP_ARITH, OP_BRANCH, OP_SUBSP, OP_JUMP: legal = 1'b1;
      default:                                                   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sher_vi_fetch_unit.sv
// SHER-VI instruction fetch unit: fetches from memory, decodes legality, holds the
// instruction for the control unit, and advances or redirects the PC on completion.
module sher_vi_fetch_unit
  import sher_vi_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [CODE_W-1:0] code,
  output logic [OPND_W-1:0] operand,
  output logic              instr_valid,
  input  logic              ctrl_done,
  input  logic              pc_load,
  input  logic [31:0]       pc_target,
  output logic [31:0]       pc,
  output logic              illegal,
  output logic [2:0]        fetch_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic         illegal_q;
  logic         legal;
  logic         fetching;
  logic         retire;

  sher_vi_opcode_check u_opcode_check (
    .code  (ir_q[CODE_MSB:CODE_LSB]),
    .legal (legal)
  );

  // mem_ack only matters while a request is outstanding
  assign fetching = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign retire   = (state_q == ST_EXEC) && ctrl_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_REQ;
      ST_REQ:    state_d = mem_ack ? ST_DECODE : ST_WAIT;
      ST_WAIT:   if (mem_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = legal ? ST_EXEC : ST_HALT;
      ST_EXEC:   if (ctrl_done) state_d = ST_REQ;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetching && mem_ack) ir_q <= mem_rdata;
      if (retire) pc_q <= pc_load ? pc_target : pc_q + 32'(PC_STEP);
      if ((state_q == ST_DECODE) && !legal) illegal_q <= 1'b1;
    end
  end

  // Handshake outputs decode from state only, never from inputs
  assign mem_rd      = fetching;
  assign instr_valid = (state_q == ST_EXEC);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign illegal     = illegal_q;
  assign code        = ir_q[CODE_MSB:CODE_LSB];
  assign operand     = ir_q[OPND_MSB:OPND_LSB];
  assign fetch_state = state_q;

endmodule

// File: tb/tb_sher_vi_fetch_unit.sv
// Directed scoreboard bench for sher_vi_fetch_unit.
module tb_sher_vi_fetch_unit;
  import sher_vi_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          STEP   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  code;
  logic [26:0] operand;
  logic        instr_valid;
  logic        ctrl_done = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = '0;
  logic [31:0] pc;
  logic        illegal;
  logic [2:0]  fetch_state;

  sher_vi_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(STEP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .code        (code),
    .operand     (operand),
    .instr_valid (instr_valid),
    .ctrl_done   (ctrl_done),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .pc          (pc),
    .illegal     (illegal),
    .fetch_state (fetch_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  code;
    logic [26:0] operand;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc;
  int          lat;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  function automatic bit is_legal(input logic [4:0] c);
    return (c == 5'd0) || (c == 5'd1) || (c == 5'd2) || (c == 5'd3) ||
           (c == 5'd5) || (c == 5'd19);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Starts in REQ; returns after the ack edge with the DUT in DECODE
  task automatic fetch(input logic [31:0] rdata, input int dly);
    logic [31:0] addr;
    exp_t        e;
    chk("req_state", 64'(fetch_state), 64'(ST_REQ));
    chk("req_rd", 64'(mem_rd), 64'd1);
    chk("req_addr", 64'(mem_addr), 64'(exp_pc));
    addr = mem_addr;
    lat = 1;
    for (int i = 0; i < dly; i++) begin
      tick();
      lat++;
      chk("wait_state", 64'(fetch_state), 64'(ST_WAIT));
      chk("wait_rd", 64'(mem_rd), 64'd1);
      chk("wait_addr", 64'(mem_addr), 64'(addr));
      chk("wait_novalid", 64'(instr_valid), 64'd0);
    end
    mem_ack = 1'b1;
    mem_rdata = rdata;
    if (is_legal(rdata[31:27])) begin
      e.pc = addr;
      e.code = rdata[31:27];
      e.operand = rdata[26:0];
      sb.push_back(e);
    end
    tick();
    lat++;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic wait_valid(input int exp_lat);
    exp_t e;
    int   n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      lat++;
      n++;
    end
    chk("valid_seen", 64'(instr_valid), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("code", 64'(code), 64'(e.code));
      chk("operand", 64'(operand), 64'(e.operand));
      chk("pc", 64'(pc), 64'(e.pc));
    end
  endtask

  task automatic retire(input bit load, input logic [31:0] tgt);
    ctrl_done = 1'b1;
    pc_load = load;
    pc_target = tgt;
    exp_pc = load ? tgt : exp_pc + 32'(STEP);
    tick();
    ctrl_done = 1'b0;
    pc_load = 1'b0;
    chk("ret_valid", 64'(instr_valid), 64'd0);
    chk("ret_state", 64'(fetch_state), 64'(ST_REQ));
    chk("ret_pc", 64'(pc), 64'(exp_pc));
    chk("ret_addr", 64'(mem_addr), 64'(exp_pc));
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_state", 64'(fetch_state), 64'(ST_IDLE));
    chk("rst_pc", 64'(pc), 64'(RST_PC));
    chk("rst_rd", 64'(mem_rd), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_code", 64'(code), 64'd0);
    chk("rst_operand", 64'(operand), 64'd0);

    rst_n = 1'b1;
    exp_pc = RST_PC;
    chk("idle_after_release", 64'(fetch_state), 64'(ST_IDLE));
    tick();

    // first fetch, ack in REQ: instr_valid in the third cycle of mem_rd
    fetch(32'h0800_0123, 0);
    chk("decode_novalid", 64'(instr_valid), 64'd0);
    wait_valid(3);

    // pc_load without ctrl_done and a stray mem_ack are both ignored in EXEC
    pc_load = 1'b1;
    pc_target = 32'h0000_0BAD;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    pc_load = 1'b0;
    mem_ack = 1'b0;
    chk("hold_state", 64'(fetch_state), 64'(ST_EXEC));
    chk("hold_valid", 64'(instr_valid), 64'd1);
    chk("hold_code", 64'(code), 64'd1);
    chk("hold_operand", 64'(operand), 64'h123);
    chk("hold_pc", 64'(pc), 64'd0);

    retire(1'b0, 32'h0);
    fetch(32'h1800_0040, 0);
    wait_valid(3);
    retire(1'b1, 32'h0000_0100);

    // slow memory: five WAIT cycles
    fetch(32'h9800_0007, 5);
    wait_valid(8);
    retire(1'b1, 32'hFFFF_FFFC);

    // sequential step from the top of the address space wraps to zero
    fetch(32'h2800_0055, 0);
    wait_valid(3);
    retire(1'b0, 32'h0);

    // undefined opcode 4 halts
    fetch(32'h2000_0000, 0);
    tick();
    chk("halt_state", 64'(fetch_state), 64'(ST_HALT));
    chk("halt_illegal", 64'(illegal), 64'd1);
    chk("halt_rd", 64'(mem_rd), 64'd0);
    chk("halt_valid", 64'(instr_valid), 64'd0);
    mem_ack = 1'b1;
    ctrl_done = 1'b1;
    pc_load = 1'b1;
    pc_target = 32'h0000_0200;
    tick();
    mem_ack = 1'b0;
    ctrl_done = 1'b0;
    pc_load = 1'b0;
    tick();
    chk("halt_stuck", 64'(fetch_state), 64'(ST_HALT));
    chk("halt_sticky", 64'(illegal), 64'd1);
    chk("halt_pc", 64'(pc), 64'd0);
    chk("halt_rd2", 64'(mem_rd), 64'd0);

    // asynchronous reset clears illegal without waiting for an edge
    rst_n = 1'b0;
    #2;
    chk("arst_state", 64'(fetch_state), 64'(ST_IDLE));
    chk("arst_illegal", 64'(illegal), 64'd0);
    chk("arst_code", 64'(code), 64'd0);
    tick();
    rst_n = 1'b1;
    exp_pc = RST_PC;
    tick();
    chk("rerun_state", 64'(fetch_state), 64'(ST_REQ));

    // reset during WAIT, then a late ack while IDLE
    tick();
    chk("mid_wait", 64'(fetch_state), 64'(ST_WAIT));
    rst_n = 1'b0;
    #1;
    chk("wrst_state", 64'(fetch_state), 64'(ST_IDLE));
    chk("wrst_rd", 64'(mem_rd), 64'd0);
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("late_state", 64'(fetch_state), 64'(ST_REQ));
    chk("late_code", 64'(code), 64'd0);
    chk("late_operand", 64'(operand), 64'd0);
    chk("late_addr", 64'(mem_addr), 64'(RST_PC));
    fetch(32'h0000_0042, 0);
    wait_valid(3);

    chk("sb_final", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sher_vi_fetch_unit.md
SHER_VI_FETCH_UNIT -- requirements
Module: sher_vi_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter PC_STEP, default 4, meaning the byte increment from one sequential instruction to the next.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 mem_addr  output  32  instruction fetch address; equals pc.
REQ-006 mem_rd  output  1  fetch request; held high until mem_ack.
REQ-007 mem_ack  input  1  memory has returned data on mem_rdata this cycle.
REQ-008 mem_rdata  input  32  instruction word.
REQ-009 code  output  5  opcode to SHER_VI_CONTROL; equals ir[31:27].
REQ-010 operand  output  27  ir[26:0], consumed by datapath.
REQ-011 instr_valid  output  1  code/operand valid; control may run.
REQ-012 ctrl_done  input  1  control has finished the current instruction (one-cycle pulse).
REQ-013 pc_load  input  1  branch/jump taken; sampled only together with ctrl_done.
REQ-014 pc_target  input  32  next PC when pc_load is asserted.
REQ-015 pc  output  32  address of the current instruction.
REQ-016 illegal  output  1  sticky flag indicating that an undefined opcode was fetched.
REQ-017 fetch_state  output  3  current FSM state, for debug and test.

Function
REQ-018 The FSM SHALL have states IDLE=0, REQ=1, WAIT=2, DECODE=3, EXEC=4 and HALT=5.
REQ-019 IDLE SHALL move unconditionally to REQ on the next edge.
REQ-020 REQ SHALL assert mem_rd; on mem_ack in the same cycle it goes to DECODE and latches ir, otherwise it goes to WAIT.
REQ-021 WAIT SHALL keep mem_rd high and mem_addr stable, and on mem_ack latch ir=mem_rdata and go to DECODE; there is no timeout.
REQ-022 DECODE SHALL check ir[31:27]: a legal code (0, 1, 2, 3, 5, 19) goes to EXEC; any other code sets illegal and goes to HALT.
REQ-023 EXEC SHALL assert instr_valid, with code and operand stable for the whole state.
REQ-024 On ctrl_done in EXEC: pc becomes pc_target if pc_load=1, else pc+PC_STEP (modulo 2^32, wraps silently); instr_valid drops on the next edge; the FSM goes to REQ.
REQ-025 ctrl_done or pc_load outside EXEC SHALL be ignored, and pc_load without ctrl_done SHALL be ignored.
REQ-026 HALT SHALL be terminal until Reset, with mem_rd=0, instr_valid=0 and illegal=1.
REQ-027 A mem_ack arriving while mem_rd=0 SHALL be ignored.
REQ-028 Minimum latency SHALL be 3 cycles from the mem_rd rising edge to instr_valid (REQ -> DECODE -> EXEC) when mem_ack is returned in the REQ cycle.
REQ-029 mem_rd, instr_valid and illegal SHALL be registered or decoded from state only, never combinational from inputs.

Reset
REQ-030 On Reset low the block SHALL immediately force fetch_state=IDLE, pc=RESET_PC, ir=0, mem_rd=0, instr_valid=0 and illegal=0; code and operand then read 0.
REQ-031 Reset asserted mid-fetch (WAIT) or mid-instruction (EXEC) SHALL abandon the operation, and a late mem_ack SHALL be ignored.
REQ-032 The first fetch SHALL begin 1 cycle after Reset deasserts (IDLE -> REQ).

Structure
REQ-033 Opcode constants (MAKE=0, ADDSP=1, ARITH=2, BRANCH=3, SUBSP=5, JUMP=19), fetch state encodings and the field boundaries 31:27 / 26:0 SHALL live in the shared package sher_vi_pkg, also used by SHER_VI_CONTROL.
REQ-034 The opcode legality check SHALL be one combinational sub-module, sher_vi_opcode_check (input code[4:0], output legal), reusable by the control unit.

Verification
REQ-035 Reset release with RESET_PC=0 and mem_ack returned in the REQ cycle with rdata=32'h0800_0123 -> mem_addr=0, instr_valid high 3 cycles after the mem_rd rising edge, code=1, operand=27'h0000123.
REQ-036 ctrl_done with pc_load=0 in EXEC at pc=0 -> pc=4, next fetch at mem_addr=4; ctrl_done with pc_load=1 and pc_target=32'h100 -> next fetch at 32'h100.
REQ-037 mem_ack delayed 5 cycles -> mem_rd and mem_addr held for 5 cycles, state stays WAIT, no early instr_valid.
REQ-038 Fetch of rdata=32'h2000_0000 (code 4) -> illegal=1, state HALT; further mem_ack and ctrl_done pulses have no effect; Reset clears illegal.
REQ-039 pc=32'hFFFF_FFFC with ctrl_done and pc_load=0 -> pc wraps to 0.
REQ-040 Reset pulsed low during WAIT, followed by a late mem_ack -> state IDLE, ir=0, and the next fetch addresses RESET_PC.
